qdr_nibble_deframer: RTL and testbench
======================================

// Module: qdr_nibble_deframer
// PURPOSE
//  Receive-side partner of the 14-bit QDR nibble serializer. It consumes the DA[3:0]/DAFRAME
//  nibble stream (one nibble per clk, frame = 4 nibbles, DAFRAME = 1,1,0,0), finds and
//  holds frame alignment, and rebuilds 14-bit words. Words are delivered through a small
//  first-word-fall-through (FWFT) FIFO with a valid/ready handshake.
//  Sits between the LVDS capture flops and the sample consumer. Runs on the same clk as
//  the transmitter. DACLK is not an input.
// PARAMETERS
//  LOCK_FRAMES  3  consecutive well-formed frames needed in VERIFY before entering LOCKED (>=1)
//  FIFO_DEPTH   4  output FIFO entries; power of two, >=2
//  CHECK_PAD    1  1: a nonzero DA[1:0] on nibble 3 is a frame error; 0: pad bits ignored
// PORTS
//  clk         in   1   system clock; one nibble per rising edge
//  reset_n     in   1   synchronous active-low reset
//  DA          in   4   nibble data from link
//  DAFRAME     in   1   frame marker from link
//  word_data   out  14  reassembled word, FIFO head
//  word_valid  out  1   FIFO not empty
//  word_ready  in   1   consumer accepts head when word_valid & word_ready
//  locked      out  1   state == LOCKED
//  frame_err   out  1   one-cycle pulse on any frame violation in VERIFY or LOCKED
//  err_cnt     out  8   saturating count of frame_err pulses
//  ovf_cnt     out  8   saturating count of words dropped on full FIFO
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge): state=HUNT, idx=0, FIFO emptied, all outputs 0,
//    input regs 0. Reset mid-frame or mid-FIFO discards everything. No partial word survives.
//  - Stage 0: DA/DAFRAME registered into r_da/r_fr, and r_fr is delayed again into p_fr.
//    All decisions use the registered values.
//  - Frame start = (p_fr==0 && r_fr==1). That nibble is idx 0.
//  - Expected pattern: idx0 F=1 -> W[13:10]; idx1 F=1 -> W[9:6]; idx2 F=0 -> W[5:2];
//    idx3 F=0 -> W[1:0]=r_da[3:2], with pad r_da[1:0] expected to be 00.
//  - idx increments modulo 4 on every nibble while in VERIFY or LOCKED.
//  - FSM:
//    HUNT: wait for a frame start, then idx=0 and go to VERIFY with good=0.
//    VERIFY: at idx3 with no violation, good++. When good==LOCK_FRAMES, go to LOCKED. Words
//      are not written to the FIFO.
//    LOCKED: at idx3 with no violation, write word W to the FIFO.
//    Any state except HUNT, on a violation: frame_err=1, err_cnt++ (saturates at 255),
//      partial word discarded, state=HUNT. If the violating nibble is itself a frame start,
//      it counts as idx0 of a new VERIFY attempt (good=0) instead of being lost.
//  - Violation = r_fr differs from the expected pattern, or CHECK_PAD && idx3 && r_da[1:0]!=0.
//  - Latency: nibble 3 on DA at edge t -> word_valid=1 after edge t+2 (FIFO was empty).
//  - FIFO:
//    Push and pop in the same cycle are both performed, including when the FIFO is full.
//    Push while full without a pop: the word is dropped, ovf_cnt++ (saturates at 255), and
//      the FIFO contents are unchanged.
//    Pop while empty is ignored. Pointers wrap modulo FIFO_DEPTH. word_data holds its value
//      while word_valid=1 && word_ready=0.
//  - locked is registered and equals (state==LOCKED). frame_err is registered and lasts one cycle.
// TESTING
//  - Reset, then 5 frames of 14'h2A5C (nibbles A,9,7,0; F=1,1,0,0) -> locked after frame 3;
//    word_data=14'h2A5C exactly twice; err_cnt=0.
//  - Locked, 14'h3FFF (F,F,F,C) -> word 14'h3FFF with CHECK_PAD=1; err_cnt unchanged.
//  - Locked, frame with F=1,0,0,0 -> frame_err pulse, locked=0 next cycle, err_cnt=1, no
//    word; relock after LOCK_FRAMES good frames.
//  - Locked, nibble 3 = 4'hD (pad 01), CHECK_PAD=1 -> frame_err, word dropped.
//    The same stimulus with CHECK_PAD=0 -> word 14'h....|2'b11 written.
//  - word_ready=0 for 6 good frames, FIFO_DEPTH=4 -> 4 words held in order, ovf_cnt=2.
//    Then word_ready=1 -> 4 words delivered, followed by word_valid=0.
//  - reset_n=0 for one cycle at idx2 of a locked frame -> state HUNT, FIFO empty, counters
//    0, no word for that frame.

Source files
------------

// File: rtl/qdr_nibble_deframer.sv
// Receive-side deframer for the 14-bit QDR nibble link: finds and holds frame alignment,
// rebuilds words and hands them out through a small first-word-fall-through FIFO.
module qdr_nibble_deframer #(
    parameter int LOCK_FRAMES = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int CHECK_PAD   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  DA,
    input  logic        DAFRAME,
    output logic [13:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        locked,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic [7:0]  ovf_cnt,
    output logic [1:0]  state_dbg
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [3:0]  r_da;
    logic        r_fr, p_fr;
    logic [1:0]  idx, idx_n;
    logic [GW-1:0] good, good_n;
    logic [11:0] acc, acc_n;
    logic        push_q, push_n;
    logic [13:0] push_word, word_n;
    logic        err_n;
    logic        frame_start, violation;

    logic [13:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, do_push;

    assign frame_start = !p_fr && r_fr;
    // Nibbles 0 and 1 carry DAFRAME=1, nibbles 2 and 3 carry DAFRAME=0.
    assign violation = (r_fr != !idx[1]) ||
                       ((CHECK_PAD != 0) && (idx == 2'd3) && (r_da[1:0] != 2'b00));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        good_n  = good;
        acc_n   = acc;
        push_n  = 1'b0;
        word_n  = push_word;
        err_n   = 1'b0;
        case (state)
            HUNT: begin
                if (frame_start) begin
                    state_n     = VERIFY;
                    idx_n       = 2'd1;
                    good_n      = '0;
                    acc_n[11:8] = r_da;
                end
            end
            default: begin
                if (violation) begin
                    err_n  = 1'b1;
                    good_n = '0;
                    // A violating nibble that is itself a frame start seeds a fresh attempt.
                    if (frame_start) begin
                        state_n     = VERIFY;
                        idx_n       = 2'd1;
                        acc_n[11:8] = r_da;
                    end else begin
                        state_n = HUNT;
                        idx_n   = 2'd0;
                    end
                end else begin
                    idx_n = idx + 2'd1;
                    case (idx)
                        2'd0: acc_n[11:8] = r_da;
                        2'd1: acc_n[7:4]  = r_da;
                        2'd2: acc_n[3:0]  = r_da;
                        default: begin
                            if (state == LOCKED) begin
                                push_n = 1'b1;
                                word_n = {acc, r_da[3:2]};
                            end else begin
                                good_n = good + GW'(1);
                                if (int'(good) + 1 == LOCK_FRAMES) state_n = LOCKED;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_da      <= '0;
            r_fr      <= 1'b0;
            p_fr      <= 1'b0;
            state     <= HUNT;
            idx       <= '0;
            good      <= '0;
            acc       <= '0;
            push_q    <= 1'b0;
            push_word <= '0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            r_da      <= DA;
            r_fr      <= DAFRAME;
            p_fr      <= r_fr;
            state     <= state_n;
            idx       <= idx_n;
            good      <= good_n;
            acc       <= acc_n;
            push_q    <= push_n;
            push_word <= word_n;
            frame_err <= err_n;
            if (err_n && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    // Handshake: word_data is the FIFO head and is valid while word_valid=1; it is consumed
    // on a rising edge where word_valid && word_ready, and holds steady until then.
    assign pop     = word_valid && word_ready;
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_push = push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !pop)      count <= count + (AW+1)'(1);
            else if (!do_push && pop) count <= count - (AW+1)'(1);
            if (push_q && !do_push && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    assign word_valid = (count != '0);
    assign word_data  = mem[rd_ptr];
    assign locked     = (state == LOCKED);
    assign state_dbg  = state;

endmodule

// File: tb/tb_qdr_nibble_deframer.sv
// Bench for qdr_nibble_deframer: two instances (pad checking on/off) share one nibble
// stream; a frame-level model predicts per-edge events, a queue models the output FIFO.
module tb_qdr_nibble_deframer;

  localparam int LOCK  = 3;
  localparam int DEPTH = 4;
  localparam int MAXC  = 8192;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  DA = '0;
  logic        DAFRAME = 1'b0;
  logic        word_ready = 1'b0;

  logic [13:0] wd0, wd1;
  logic        wv0, wv1, lk0, lk1, fe0, fe1;
  logic [7:0]  ec0, ec1, oc0, oc1;
  logic [1:0]  sd0, sd1;

  qdr_nibble_deframer #(.LOCK_FRAMES(LOCK), .FIFO_DEPTH(DEPTH), .CHECK_PAD(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .DA(DA), .DAFRAME(DAFRAME),
    .word_data(wd0), .word_valid(wv0), .word_ready(word_ready),
    .locked(lk0), .frame_err(fe0), .err_cnt(ec0), .ovf_cnt(oc0), .state_dbg(sd0)
  );

  qdr_nibble_deframer #(.LOCK_FRAMES(LOCK), .FIFO_DEPTH(DEPTH), .CHECK_PAD(0)) u_dut_np (
    .clk(clk), .reset_n(reset_n), .DA(DA), .DAFRAME(DAFRAME),
    .word_data(wd1), .word_valid(wv1), .word_ready(word_ready),
    .locked(lk1), .frame_err(fe1), .err_cnt(ec1), .ovf_cnt(oc1), .state_dbg(sd1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_mode = 1;

  bit          ev_err  [2][MAXC];
  logic [1:0]  ev_lock [2][MAXC];
  bit          ev_push [2][MAXC];
  logic [13:0] ev_word [2][MAXC];

  int good_run [2];
  bit aligned  [2];

  bit exp_locked [2];
  bit exp_fe     [2];
  int exp_err    [2];
  int exp_ovf    [2];
  logic [13:0] exp_q0[$];
  logic [13:0] exp_q1[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [13:0] q_front(input int i);
    return (i == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_pop(input int i);
    if (i == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic q_push(input int i, input logic [13:0] w);
    if (i == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  // ---------------- frame-level reference model ----------------
  function automatic bit pad_checked(input int i);
    return (i == 0);
  endfunction

  task automatic model_violation(input int i, input int e);
    if (e + 1 < MAXC) begin
      ev_err[i][e+1] = 1'b1;
      if (good_run[i] == LOCK) ev_lock[i][e+1] = 2'd2;
    end
    good_run[i] = 0;
    aligned[i]  = 1'b0;
  endtask

  task automatic model_good(input int i, input int e, input logic [13:0] w);
    if (good_run[i] == LOCK) begin
      if (e + 2 < MAXC) begin
        ev_push[i][e+2] = 1'b1;
        ev_word[i][e+2] = w;
      end
    end else begin
      good_run[i]++;
      if (good_run[i] == LOCK && e + 1 < MAXC) ev_lock[i][e+1] = 2'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_nib(input logic [3:0] da, input logic fr, output int e);
    @(negedge clk);
    reset_n = 1'b1;
    DA = da;
    DAFRAME = fr;
    word_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
    e = cyc + 1;
  endtask

  // kind 0: F=1,1,0,0 ; kind 1: malformed F=1,0,0,0
  task automatic send_frame(input int kind, input logic [3:0] n0, input logic [3:0] n1,
                            input logic [3:0] n2, input logic [3:0] n3);
    logic [3:0] n [4];
    int e;
    n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
    for (int k = 0; k < 4; k++) begin
      drive_nib(n[k], (k < 2) && !(kind == 1 && k == 1), e);
      for (int i = 0; i < 2; i++) begin
        if (k == 0) aligned[i] = 1'b1;
        if (kind == 1 && k == 1) model_violation(i, e);
        if (kind == 0 && k == 3) begin
          if (pad_checked(i) && n3[1:0] != 2'b00) model_violation(i, e);
          else model_good(i, e, {n0, n1, n2, n3[3:2]});
        end
      end
    end
  endtask

  task automatic send_word(input logic [13:0] w);
    send_frame(0, w[13:10], w[9:6], w[5:2], {w[1:0], 2'b00});
  endtask

  task automatic send_idle(input int count);
    int e;
    for (int c = 0; c < count; c++) begin
      drive_nib(4'($urandom_range(0, 15)), 1'b0, e);
      for (int i = 0; i < 2; i++) if (aligned[i]) model_violation(i, e);
    end
  endtask

  task automatic do_reset(input int count);
    for (int c = 0; c < count; c++) begin
      @(negedge clk);
      reset_n = 1'b0;
      DA = '0;
      DAFRAME = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      good_run[i] = 0;
      aligned[i]  = 1'b0;
    end
  endtask

  // ---------------- per-edge model update and output checks ----------------
  task automatic check_inst(input int i, input logic wv, input logic [13:0] wd, input logic lk,
                            input logic fe, input logic [7:0] ec, input logic [7:0] oc);
    check_val($sformatf("u%0d_word_valid", i), 32'(wv), 32'(q_size(i) != 0));
    if (q_size(i) != 0) check_val($sformatf("u%0d_word_data", i), 32'(wd), 32'(q_front(i)));
    check_val($sformatf("u%0d_locked", i), 32'(lk), 32'(exp_locked[i]));
    check_val($sformatf("u%0d_frame_err", i), 32'(fe), 32'(exp_fe[i]));
    check_val($sformatf("u%0d_err_cnt", i), 32'(ec), exp_err[i]);
    check_val($sformatf("u%0d_ovf_cnt", i), 32'(oc), exp_ovf[i]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < 2; i++) begin
          exp_locked[i] = 1'b0;
          exp_fe[i] = 1'b0;
          exp_err[i] = 0;
          exp_ovf[i] = 0;
          for (int c = cyc; c < cyc + 4 && c < MAXC; c++) begin
            ev_err[i][c] = 1'b0;
            ev_lock[i][c] = 2'd0;
            ev_push[i][c] = 1'b0;
          end
        end
      end else if (cyc < MAXC) begin
        for (int i = 0; i < 2; i++) begin
          bit pop;
          exp_fe[i] = ev_err[i][cyc];
          if (ev_err[i][cyc] && exp_err[i] < 255) exp_err[i]++;
          if (ev_lock[i][cyc] == 2'd1) exp_locked[i] = 1'b1;
          if (ev_lock[i][cyc] == 2'd2) exp_locked[i] = 1'b0;
          pop = (q_size(i) != 0) && word_ready;
          if (ev_push[i][cyc] && q_size(i) == DEPTH && !pop) begin
            if (exp_ovf[i] < 255) exp_ovf[i]++;
          end else begin
            if (pop) q_pop(i);
            if (ev_push[i][cyc]) q_push(i, ev_word[i][cyc]);
          end
        end
      end
      @(negedge clk);
      check_inst(0, wv0, wd0, lk0, fe0, ec0, oc0);
      check_inst(1, wv1, wd1, lk1, fe1, ec1, oc1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < MAXC; c++) begin
        ev_err[i][c] = 1'b0;
        ev_lock[i][c] = 2'd0;
        ev_push[i][c] = 1'b0;
        ev_word[i][c] = '0;
      end
    end
    do_reset(3);

    rdy_mode = 1;
    repeat (5) send_word(14'h2A5C);
    send_word(14'h3FFF);
    send_frame(1, 4'hA, 4'h9, 4'h7, 4'h0);
    repeat (4) send_word(14'h1234);
    send_frame(0, 4'hA, 4'h9, 4'h7, 4'hD);
    repeat (4) send_word(14'h0F0F);

    rdy_mode = 0;
    for (int k = 0; k < 6; k++) send_word(14'(14'h1000 + k));
    rdy_mode = 1;
    send_idle(8);

    repeat (4) send_word(14'h2222);
    drive_nib(4'hA, 1'b1, e);
    drive_nib(4'h9, 1'b1, e);
    do_reset(1);
    repeat (5) send_word(14'h3333);

    for (int it = 0; it < 160; it++) begin
      int r;
      logic [13:0] w;
      rdy_mode = ((it % 30) < 8) ? 0 : 2;
      r = $urandom_range(0, 9);
      w = 14'($urandom_range(0, 16383));
      if (r < 7)       send_word(w);
      else if (r == 7) send_frame(1, w[13:10], w[9:6], w[5:2], {w[1:0], 2'b00});
      else if (r == 8) send_frame(0, w[13:10], w[9:6], w[5:2], {w[1:0], 2'($urandom_range(1, 3))});
      else             send_idle($urandom_range(1, 5));
    end

    rdy_mode = 1;
    send_idle(12);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
